// File: rtl/piso16_tx.sv
// 16-bit parallel-in/serial-out transmitter, MSB first, with a ready-stalled serial handshake.
// Define PISO_PARITY_EN to append an even-parity bit as a 17th serial bit.
module piso16_tx (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] din,
    input  logic        ld,
    input  logic        rdy,
    output logic        sout,
    output logic        sout_vld,
    output logic        busy,
    output logic        done
);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd3} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] sreg_q, sreg_d;
    logic [3:0]  cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic        par_q, par_d;
`endif

    // Handshake: a bit moves on a rising edge where sout_vld && rdy; while rdy is low
    // sout_vld stays high and sout holds, so the receiver may stall for any number of cycles.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (ld) state_d = SHIFT;
            end
            SHIFT: begin
                if (rdy && (cnt_q == 4'd15)) begin
`ifdef PISO_PARITY_EN
                    state_d = PAR;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                if (rdy) state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
`ifdef PISO_PARITY_EN
        par_d  = par_q;
`endif
        if (state_q == IDLE && ld) begin
            sreg_d = din;
            cnt_d  = 4'd0;
`ifdef PISO_PARITY_EN
            par_d  = ^din;
`endif
        end else if (state_q == SHIFT && rdy) begin
            sreg_d = {sreg_q[14:0], 1'b0};
            cnt_d  = cnt_q + 4'd1;
        end
    end

    // Serial output is a mux of registers only, so din never reaches sout combinationally.
    always_comb begin
        sout     = 1'b0;
        sout_vld = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: busy = 1'b0;
            SHIFT: begin
                sout_vld = 1'b1;
                sout     = sreg_q[15];
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                sout_vld = 1'b1;
                sout     = par_q;
            end
`endif
            DONE:    done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_piso16_tx.sv
// Bench for piso16_tx: directed frames plus randomized frames with random rdy stalls.
// Expected serial bits come from a word-level model pushed into a queue and popped by a monitor.
module tb_piso16_tx;

`ifdef PISO_PARITY_EN
    localparam int NBITS = 17;
`else
    localparam int NBITS = 16;
`endif

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [15:0] din = '0;
    logic        ld  = 1'b0;
    logic        rdy = 1'b1;
    logic        sout, sout_vld, busy, done;

    int total = 0;
    int bad   = 0;
    int rdy_mode = 0;           // 0: rdy=1, 1: random, 2: rdy=0
    logic [1:0] exp_q[$];       // {last_bit_of_frame, bit}
    logic exp_done = 1'b0;

    piso16_tx dut (
        .clk(clk), .clr(clr), .din(din), .ld(ld), .rdy(rdy),
        .sout(sout), .sout_vld(sout_vld), .busy(busy), .done(done)
    );

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            1:       rdy = ($urandom_range(0, 3) != 0);
            2:       rdy = 1'b0;
            default: rdy = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a word becomes NBITS serial bits, MSB first, then even parity
    task automatic push_frame(input logic [15:0] w);
        for (int i = 15; i >= 0; i--)
            exp_q.push_back({(NBITS == 16 && i == 0), w[i]});
        if (NBITS == 17)
            exp_q.push_back({1'b1, ^w});
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (clr) begin
            exp_q.delete();
            exp_done = 1'b0;
        end else begin
            chk("done_pulse", done, exp_done);
            if (done) chk("vld_during_done", sout_vld, 0);
            exp_done = 1'b0;
            if (sout_vld && rdy) begin
                chk("bit_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    chk("serial_bit", sout, e[0]);
                    if (e[1]) exp_done = 1'b1;
                end
            end
        end
    end

    // driver tasks (all return at posedge+1)
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [15:0] w);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            step();
        end
        chk("idle_before_load", busy, 0);
        ld  = 1'b1;
        din = w;
        push_frame(w);
        step();
        ld  = 1'b0;
        din = 16'($urandom);
    endtask

    task automatic wait_done(inout int c, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done) break;
            step();
            c++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_sout"}, sout, 0);
        chk({tag, "_vld"}, sout_vld, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int c;
        logic [15:0] w;

        step();
        step();
        clr = 1'b0;
        check_idle_outputs("reset");

        // basic transfer with latency checks
        rdy_mode = 0;
        load_frame(16'hA5C3);
        chk("first_bit_vld", sout_vld, 1);
        chk("first_bit_val", sout, 1);
        c = 1;
        wait_done(c, 60);
        chk("basic_done_cycle", c, NBITS + 1);
        step();
        chk("basic_busy_after", busy, 0);

        // stall: rdy low in cycles 3..5
        load_frame(16'h8001);
        step();
        step();
        rdy_mode = 2;
        for (int k = 3; k <= 5; k++) begin
            chk("stall_sout", sout, 0);
            chk("stall_vld", sout_vld, 1);
            step();
        end
        rdy_mode = 0;
        c = 6;
        wait_done(c, 60);
        chk("stall_done_cycle", c, NBITS + 4);

        // abort with clr in cycle 7
        step();
        load_frame(16'hFFFF);
        repeat (5) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_idle_outputs("abort");
        repeat (25) step();
        load_frame(16'h0F0F);
        c = 1;
        wait_done(c, 60);
        chk("after_abort_done_cycle", c, NBITS + 1);

        // load while busy is ignored
        step();
        load_frame(16'hFFFF);
        repeat (3) step();
        ld  = 1'b1;
        din = 16'h1234;
        repeat (5) step();
        ld  = 1'b0;
        c = 9;
        wait_done(c, 60);
        chk("busy_load_done_cycle", c, NBITS + 1);

        // back-to-back with ld held high
        step();
        load_frame(16'h0001);
        ld  = 1'b1;
        din = 16'h0003;
        push_frame(16'h0003);
        repeat (NBITS + 1) step();
        chk("b2b_gap_vld", sout_vld, 0);
        chk("b2b_gap_busy", busy, 0);
        step();
        ld = 1'b0;
        chk("b2b_second_vld", sout_vld, 1);
        chk("b2b_second_busy", busy, 1);
        c = NBITS + 3;
        wait_done(c, 60);
        chk("b2b_second_done_cycle", c, 2 * NBITS + 3);

        // randomized frames with random stalls and ignored loads
        for (int n = 0; n < 30; n++) begin
            rdy_mode = 1;
            repeat ($urandom_range(0, 3)) step();
            w = 16'($urandom);
            load_frame(w);
            if ($urandom_range(0, 1) == 1) begin
                step();
                ld  = 1'b1;
                din = 16'($urandom);
                step();
                ld  = 1'b0;
            end
            c = 0;
            wait_done(c, 400);
        end

        rdy_mode = 0;
        repeat (4) step();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
